lib_hndsk_fifo: RTL and testbench
=================================

Name: lib_hndsk_fifo

Overview:
- Parametrised elastic successor to the single-entry valid/ready register slice.
- Stores DEPTH entries and sustains one transfer per cycle in steady state.
- Exposes occupancy and an almost-full flag.
- Sits between pipeline stages (CPU/memory interface paths) that need decoupling deeper than one word, with no combinational ready path from output to input.

Parameters:
D_WIDTH, 16, payload width in bits (>=1)
DEPTH, 4, entry count; power of two, >=2
AFULL_TH, DEPTH-1, almost-full threshold; 1..DEPTH

Ports:
clk    input   1                    clock, all logic rising-edge
rst    input   1                    synchronous reset, active-high
vldi   input   1                    upstream valid
rdyi   output  1                    ready to upstream
datai  input   D_WIDTH              upstream payload
vldo   output  1                    valid to downstream
rdyo   input   1                    downstream ready
datao  output  D_WIDTH              payload to downstream
count  output  $clog2(DEPTH+1)      current occupancy
afull  output  1                    count >= AFULL_TH

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Storage: DEPTH x D_WIDTH flop array, wr_ptr and rd_ptr of $clog2(DEPTH) bits, and an occupancy counter cnt of $clog2(DEPTH+1) bits.
- Pointers wrap naturally modulo DEPTH.
- push = vldi & rdyi; pop = vldo & rdyo.
- rdyi = (cnt != DEPTH) & !rst. Depends only on state and rst; never on rdyo or vldi.
- vldo = (cnt != 0) & !rst.
- datao = mem[rd_ptr]. It is a flop output with no mux path from datai.
- count = cnt; afull = (cnt >= AFULL_TH).
- Latency: a word accepted at edge N is presented (vldo=1) in cycle N+1. Minimum latency is 1 cycle; there is no bypass.
- Counter updates:
  - push only: cnt+1.
  - pop only: cnt-1.
  - push and pop together: cnt unchanged, both pointers advance.
- Full (cnt=DEPTH): rdyi=0. A same-cycle pop does not enable a push; rdyi rises in the following cycle. Throughput at full is therefore 1 word per 2 cycles only while full.
- Empty (cnt=0): vldo=0, rdyo ignored, no pop.
- Order: strict FIFO, no loss, no duplication.
- Data stability: while vldo=1 and rdyo=0, datao and vldo hold stable.
- Upstream protocol: the bench must hold vldi/datai stable until accepted; the block does not check this.
- Reset (at any time, including mid-stream):
  - At the next clk edge: cnt=0, wr_ptr=0, rd_ptr=0, all mem entries=0, and all stored data is discarded.
  - While rst is high: rdyi=0, vldo=0.
  - First cycle after release: rdyi=1, vldo=0, datao=0, count=0, afull=0 (afull=1 only if AFULL_TH were 0, which is illegal).
- Invalid parameter values (DEPTH not a power of two, AFULL_TH out of range) must trigger an elaboration-time $error.

Optional Feature:
- Macro: LIB_HNDSK_FLUSH_EN.
- Defined: adds input port flush (1 bit, active-high, synchronous).
  - At the edge where flush=1: cnt, wr_ptr and rd_ptr return to 0. Mem contents are not cleared.
  - Any push or pop in that cycle is ignored.
  - While flush=1: rdyi=0, vldo=0.
  - rst has priority over flush.
- Undefined: no flush port; the behaviour is as above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> rdyi=1, vldo=0, count=0, afull=0, datao=16'h0000.
- Streaming (DEPTH=4), rdyo=1 held, push 0x0001..0x0010 one per cycle -> vldo from cycle 1 after first push, outputs 0x0001..0x0010 in order, count stays 1, 16 words in 17 cycles.
- Fill to full: rdyo=0, push 0xA0,0xA1,0xA2,0xA3 -> count=1,2,3,4; afull=1 at count=3 (AFULL_TH=3); rdyi=0 at count=4; vldi held with 0xA4 is not accepted.
- Full with simultaneous pop: from the full state, rdyo=1 for 1 cycle with vldi=1 data 0xA4 -> datao 0xA0 popped, count=3, 0xA4 not accepted that cycle; accepted next cycle, count=4; drain order 0xA1,0xA2,0xA3,0xA4.
- Backpressure hold and wrap: random rdyo (50%) over 100 words 0x0000..0x0063 -> datao and vldo stable while stalled, pointers wrap past 3, output sequence matches input exactly.
- Reset mid-operation: count=3 (0xB0..0xB2), rst=1 for 1 cycle -> next cycle count=0, vldo=0, datao=0; new push 0xC0 emerges first, with no 0xB* word.

Source files
------------

// File: rtl/lib_hndsk_fifo.sv
// Elastic valid/ready FIFO: DEPTH flop entries, registered output, no bypass.
// Optional synchronous flush port enabled by defining LIB_HNDSK_FLUSH_EN.
module lib_hndsk_fifo #(
  parameter int D_WIDTH  = 16,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef LIB_HNDSK_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       vldi,
  output logic                       rdyi,
  input  logic [D_WIDTH-1:0]         datai,
  output logic                       vldo,
  input  logic                       rdyo,
  output logic [D_WIDTH-1:0]         datao,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       afull
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AFTH = CW'(AFULL_TH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lib_hndsk_fifo: DEPTH must be a power of two >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("lib_hndsk_fifo: AFULL_TH must be in 1..DEPTH");
  end
  if (D_WIDTH < 1) begin : g_bad_width
    $error("lib_hndsk_fifo: D_WIDTH must be >= 1");
  end

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      cnt;
  logic               flsh;
  logic               push;
  logic               pop;

`ifdef LIB_HNDSK_FLUSH_EN
  assign flsh = flush;
`else
  assign flsh = 1'b0;
`endif

  // Handshake outputs depend only on state, rst and flush.
  assign rdyi  = (cnt != FULL) & ~rst & ~flsh;
  assign vldo  = (cnt != '0) & ~rst & ~flsh;
  assign push  = vldi & rdyi;
  assign pop   = vldo & rdyo;
  assign datao = mem[rd_ptr];
  assign count = cnt;
  assign afull = (cnt >= AFTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flsh) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= datai;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lib_hndsk_fifo.sv
// Directed bench for lib_hndsk_fifo with a scoreboard queue.
// Inputs change 1ns after posedge; outputs observed on negedge.
module tb_lib_hndsk_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          vldi;
  logic          rdyi;
  logic [DW-1:0] datai;
  logic          vldo;
  logic          rdyo;
  logic [DW-1:0] datao;
  logic [CW-1:0] count;
  logic          afull;

  always #5 clk = ~clk;

  lib_hndsk_fifo #(
    .D_WIDTH (DW),
    .DEPTH   (DEPTH),
    .AFULL_TH(3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef LIB_HNDSK_FLUSH_EN
    .flush(1'b0),
`endif
    .vldi (vldi),
    .rdyi (rdyi),
    .datai(datai),
    .vldo (vldo),
    .rdyo (rdyo),
    .datao(datao),
    .count(count),
    .afull(afull)
  );

  int            n_chk = 0;
  int            n_err = 0;
  int            n_out = 0;
  logic [DW-1:0] exp_q[$];
  bit            rnd_mode = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: record accepted words, compare delivered words.
  always @(negedge clk) begin
    if (!rst && vldi && rdyi) exp_q.push_back(datai);
    if (!rst && prev_stall) begin
      chk("hold_vldo", 32'(vldo), 1);
      chk("hold_data", 32'(datao), 32'(prev_data));
    end
    if (!rst && vldo && rdyo) begin
      if (exp_q.size() == 0) chk("out_underflow", exp_q.size(), 1);
      else chk("out_data", 32'(datao), 32'(exp_q.pop_front()));
      n_out++;
    end
    prev_stall = !rst && vldo && !rdyo;
    prev_data  = datao;
  end

  task automatic push_word(input logic [DW-1:0] d);
    bit acc = 1'b0;
    int n = 0;
    vldi  = 1'b1;
    datai = d;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = rdyi;
      @(posedge clk);
      #1;
      if (rnd_mode) rdyo = 1'($urandom_range(0, 1));
      n++;
    end
    if (!acc) chk("push_timeout", 32'(acc), 1);
  endtask

  task automatic drain();
    int n = 0;
    vldi = 1'b0;
    if (!rnd_mode) rdyo = 1'b1;
    while (count != 0 && n < 500) begin
      @(posedge clk);
      #1;
      if (rnd_mode) rdyo = 1'($urandom_range(0, 1));
      n++;
    end
    chk("drain_empty", 32'(count), 0);
  endtask

  initial begin
    rst   = 1'b1;
    vldi  = 1'b0;
    datai = '0;
    rdyo  = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdyi", 32'(rdyi), 0);
    chk("rst_vldo", 32'(vldo), 0);
    rst = 1'b0;
    #1;
    chk("idle_rdyi", 32'(rdyi), 1);
    chk("idle_vldo", 32'(vldo), 0);
    chk("idle_count", 32'(count), 0);
    chk("idle_afull", 32'(afull), 0);
    chk("idle_datao", 32'(datao), 0);

    // Streaming with rdyo held high
    rdyo = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      push_word(DW'(i));
      chk("stream_count", 32'(count), 1);
    end
    vldi = 1'b0;
    chk("stream_out_mid", n_out, 15);
    @(posedge clk);
    #1;
    chk("stream_out_total", n_out, 16);
    chk("stream_empty", 32'(count), 0);

    // Fill to full
    rdyo = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_word(DW'(16'h00A0 + k));
      chk("fill_count", 32'(count), k + 1);
      chk("fill_afull", 32'(afull), (k + 1 >= 3) ? 1 : 0);
      chk("fill_rdyi", 32'(rdyi), (k + 1 < 4) ? 1 : 0);
    end
    datai = 16'h00A4;
    @(negedge clk);
    chk("full_rdyi", 32'(rdyi), 0);
    @(posedge clk);
    #1;
    chk("full_hold_count", 32'(count), 4);

    // Full with simultaneous pop
    rdyo = 1'b1;
    @(negedge clk);
    chk("fpop_rdyi", 32'(rdyi), 0);
    @(posedge clk);
    #1;
    rdyo = 1'b0;
    chk("fpop_count", 32'(count), 3);
    chk("fpop_afull", 32'(afull), 1);
    @(negedge clk);
    chk("fpop_rdyi_next", 32'(rdyi), 1);
    @(posedge clk);
    #1;
    vldi = 1'b0;
    chk("fpop_refill", 32'(count), 4);
    drain();
    chk("fill_out_total", n_out, 21);

    // Random backpressure with pointer wrap
    rnd_mode = 1'b1;
    rdyo = 1'($urandom_range(0, 1));
    for (int i = 0; i < 100; i++) begin
      push_word(DW'(i));
    end
    drain();
    rnd_mode = 1'b0;
    rdyo = 1'b0;
    chk("bp_out_total", n_out, 121);

    // Reset mid-operation
    for (int k = 0; k < 3; k++) begin
      push_word(DW'(16'h00B0 + k));
    end
    vldi = 1'b0;
    chk("mid_count", 32'(count), 3);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_rdyi", 32'(rdyi), 0);
    chk("mid_rst_vldo", 32'(vldo), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_post_count", 32'(count), 0);
    chk("mid_post_vldo", 32'(vldo), 0);
    chk("mid_post_datao", 32'(datao), 0);
    chk("mid_post_rdyi", 32'(rdyi), 1);
    chk("mid_post_afull", 32'(afull), 0);
    push_word(16'h00C0);
    vldi = 1'b0;
    chk("c0_vldo", 32'(vldo), 1);
    chk("c0_datao", 32'(datao), 32'h00C0);
    drain();
    chk("final_out_total", n_out, 122);
    chk("final_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
